// File: rtl/alu_issue.sv
// Issue/writeback stage feeding an 8-bit ALU: 8x8 register file, one EX slot, writeback one edge later.
// Optional macro ALU_ISSUE_FWD_EN: forward alu_c to dependent sources instead of stalling.
module alu_issue (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [2:0] in_rd,
  input  logic [2:0] in_rs1,
  input  logic [2:0] in_rs2,
  input  logic       load_en,
  input  logic [2:0] load_addr,
  input  logic [7:0] load_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_control,
  input  logic [7:0] alu_c,
  input  logic       alu_f,
  output logic       wb_valid,
  output logic [2:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       flag_q,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [2:0] OP_NOP = 3'b111;

  logic [7:0] rf [0:7];

  logic       ex_valid;
  logic [2:0] ex_op;
  logic [2:0] ex_rd;
  logic [7:0] ex_a;
  logic [7:0] ex_b;

  logic       wb_en;
  logic       haz1;
  logic       haz2;
  logic       hazard;
  logic       accept;
  logic [7:0] src_a;
  logic [7:0] src_b;

  // A NOP in EX never writes back, so it can never be the source of a hazard.
  assign wb_en  = ex_valid && (ex_op != OP_NOP);
  assign haz1   = wb_en && (ex_rd != 3'd0) && (in_rs1 == ex_rd);
  assign haz2   = wb_en && (ex_rd != 3'd0) && (in_rs2 == ex_rd);
  assign hazard = haz1 || haz2;

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    src_a = rf[in_rs1];
    src_b = rf[in_rs2];
`ifdef ALU_ISSUE_FWD_EN
    if (haz1) src_a = alu_c;
    if (haz2) src_b = alu_c;
`endif
  end

`ifdef ALU_ISSUE_FWD_EN
  assign in_ready = ~rst;
`else
  assign in_ready = ~rst & ~hazard;
`endif

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_op    <= 3'd0;
      ex_rd    <= 3'd0;
      ex_a     <= 8'd0;
      ex_b     <= 8'd0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_op    <= in_op;
      ex_rd    <= in_rd;
      ex_a     <= src_a;
      ex_b     <= src_b;
    end else begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= 3'd0;
      wb_data  <= 8'd0;
      flag_q   <= 1'b0;
    end else if (wb_en) begin
      wb_valid <= 1'b1;
      wb_rd    <= ex_rd;
      wb_data  <= alu_c;
      flag_q   <= alu_f;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // NOTE: the register file is small and its reset contents are architecturally visible, so it is reset.
  // rf[0] is never written and stays 0; writeback beats a load to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
    end else begin
      for (int i = 1; i < 8; i++) begin
        if (wb_en && (ex_rd == 3'(i)))
          rf[i] <= alu_c;
        else if (load_en && (load_addr == 3'(i)))
          rf[i] <= load_data;
      end
    end
  end

  assign alu_a       = ex_a;
  assign alu_b       = ex_b;
  assign alu_control = ex_op;
  assign dbg_data    = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU closes the loop, writebacks are checked by a monitor.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = 3'd0, in_rd = 3'd0, in_rs1 = 3'd0, in_rs2 = 3'd0;
  logic       load_en = 1'b0;
  logic [2:0] load_addr = 3'd0;
  logic [7:0] load_data = 8'd0;
  logic [7:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_control;
  logic       alu_f;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_q;
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;

`ifdef ALU_ISSUE_FWD_EN
  localparam int DEP_STALL = 0;
`else
  localparam int DEP_STALL = 1;
`endif

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;
  int  total = 0;
  int  bad   = 0;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_c(alu_c), .alu_f(alu_f),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flag_q(flag_q),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; the flag is the result sign bit.
  always_comb begin
    case (alu_control)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = alu_a >> 1;
      3'b011:  alu_c = ~(alu_a | alu_b);
      3'b100:  alu_c = ~(alu_a & alu_b);
      3'b110:  alu_c = alu_a << 1;
      3'b101:  alu_c = alu_a;
      default: alu_c = 8'd0;
    endcase
    alu_f = alu_c[7];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_spurious", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        check("wb_data", 32'(wb_data), 32'(mon_e.data));
      end
    end
  end

  task automatic load(input logic [2:0] addr, input logic [7:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic dbg_check(input string name, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  // Presents one instruction, waits out any stall, returns on the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] exp, input bit track,
                       input int exp_stalls);
    int  stalls = 0;
    wb_t e;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    #1;
    while (!in_ready && stalls < 8) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (in_ready) begin
      if (track && op != 3'b111) begin
        e.rd = rd; e.data = exp;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    load(3'd1, 8'd15);
    load(3'd2, 8'd5);
    load(3'd0, 8'hAA);
    dbg_check("load_r1", 3'd1, 8'd15);
    dbg_check("load_r0_dropped", 3'd0, 8'd0);
    @(negedge clk);

    // Basic add r3 = r1 + r2
    issue(3'b000, 3'd3, 3'd1, 3'd2, 8'd20, 1'b1, 0);
    check("add_alu_a", 32'(alu_a), 32'd15);
    check("add_alu_b", 32'(alu_b), 32'd5);
    check("add_alu_ctl", 32'(alu_control), 32'd0);
    @(negedge clk);
    dbg_check("add_r3", 3'd3, 8'd20);
    @(negedge clk);

    // Dependent chain: sub r4 = r3 - r2
    issue(3'b000, 3'd3, 3'd1, 3'd2, 8'd20, 1'b1, 0);
    issue(3'b001, 3'd4, 3'd3, 3'd2, 8'd15, 1'b1, DEP_STALL);
    @(negedge clk);
    dbg_check("chain_r4", 3'd4, 8'd15);
    @(negedge clk);

    // r0 destination: writeback reported, register stays 0, never a hazard
    issue(3'b100, 3'd0, 3'd1, 3'd2, 8'hFA, 1'b1, 0);
    issue(3'b000, 3'd5, 3'd0, 3'd1, 8'd15, 1'b1, 0);
    check("nand_flag", 32'(flag_q), 32'd1);
    dbg_check("r0_zero", 3'd0, 8'd0);
    @(negedge clk);
    dbg_check("r5_add", 3'd5, 8'd15);
    check("add_flag", 32'(flag_q), 32'd0);
    @(negedge clk);

    // NOP with rd=r1 is not a hazard; writeback beats a same-edge load
    issue(3'b111, 3'd1, 3'd0, 3'd0, 8'd0, 1'b1, 0);
    issue(3'b000, 3'd6, 3'd1, 3'd1, 8'd30, 1'b1, 0);
    load_en = 1'b1; load_addr = 3'd6; load_data = 8'h55;
    @(negedge clk);
    load_en = 1'b0;
    dbg_check("r6_contention", 3'd6, 8'd30);
    @(negedge clk);

    // Shifts, logic and pass-through
    issue(3'b010, 3'd7, 3'd1, 3'd0, 8'd7, 1'b1, 0);
    check("srl_ctl", 32'(alu_control), 32'd2);
    issue(3'b110, 3'd7, 3'd1, 3'd0, 8'd30, 1'b1, 0);
    check("sll_ctl", 32'(alu_control), 32'd6);
    issue(3'b011, 3'd7, 3'd1, 3'd2, 8'hF0, 1'b1, 0);
    check("nor_ctl", 32'(alu_control), 32'd3);
    issue(3'b101, 3'd7, 3'd2, 3'd0, 8'd5, 1'b1, 0);
    check("pass_ctl", 32'(alu_control), 32'd5);
    @(negedge clk);
    dbg_check("r7_pass", 3'd7, 8'd5);
    @(negedge clk);

    // Reset with an instruction in EX: squashed, no writeback
    issue(3'b000, 3'd2, 3'd1, 3'd1, 8'd30, 1'b0, 0);
    check("inflight_alu_a", 32'(alu_a), 32'd15);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_alu", {8'd0, alu_a, alu_b, 5'd0, alu_control}, 32'd0);
    check("mid_rst_wb", {19'd0, wb_valid, wb_rd, wb_data, flag_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_release_ready", 32'(in_ready), 32'd1);
    for (int a = 0; a < 8; a++) dbg_check("rst_rf_zero", 3'(a), 8'd0);
    @(negedge clk);
    check("squash_no_wb", 32'(wb_valid), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/writeback stage directly upstream of the 8-bit ALU. It accepts one decoded instruction per cycle over a valid/ready handshake and reads both operands from an internal 8×8 register file. It drives the ALU's a/b/control inputs from a registered execute (EX) slot, then writes the ALU result `c` and flag `f` back on the following clock edge. RAW hazards against the in-flight instruction are resolved by forwarding or stalling, selected at compile time.

## Interface
- No parameters; widths are fixed (8-bit data, 3-bit register index, 3-bit ALU control).
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: stage accepts when `in_valid && in_ready` at a rising edge.
- `in_op` in 3: ALU control code. 000 add, 001 sub, 010 srl, 011 nor, 100 nand, 110 sll, 101 pass-through, 111 NOP.
- `in_rd`, `in_rs1`, `in_rs2` in 3 each: destination and source register indices.
- `load_en`, `load_addr[2:0]`, `load_data[7:0]` in: direct register-file write port for the loader/bench.
- `alu_a`, `alu_b` out 8: ALU operands, driven from the EX slot.
- `alu_control` out 3: ALU opcode, driven from the EX slot.
- `alu_c` in 8: ALU result (combinational from `alu_a`/`alu_b`/`alu_control`).
- `alu_f` in 1: ALU flag output.
- `wb_valid` out 1: one-cycle pulse when a writeback occurred on the previous edge.
- `wb_rd` out 3, `wb_data` out 8: index and value of the last writeback.
- `flag_q` out 1: last captured `alu_f`.
- `dbg_addr` in 3, `dbg_data` out 8: combinational register-file read port.

## Operation
- Register file `r0..r7`. `r0` always reads 0; writes to `r0` are discarded.
- **EX slot contents:** `ex_valid`, `ex_op`, `ex_rd`, `ex_a`, `ex_b`. `alu_a = ex_a`, `alu_b = ex_b`, `alu_control = ex_op`.
- **On accept:**
  - `ex_valid <= 1`, and op/rd are captured.
  - `ex_a`/`ex_b` take the operand values resolved as described under Configuration.
- **No accept:** `ex_valid <= 0`; `ex_a`/`ex_b`/`ex_op` hold their values.
- **Writeback** occurs on any edge where `ex_valid && ex_op != 111`:
  - `r[ex_rd] <= alu_c`, unless `ex_rd == 0`.
  - `flag_q <= alu_f` (also updated when `ex_rd == 0`).
  - `wb_valid <= 1`, `wb_rd <= ex_rd`, `wb_data <= alu_c`.
  - Otherwise `wb_valid <= 0`, and `wb_rd`/`wb_data`/`flag_q` hold.
- **NOP (111):** occupies EX for one cycle. No writeback, no flag update, never a hazard source.
- **Op 101:** passed to the ALU unchanged. Its result is written back like any other op.
- **Hazard:** exists when `ex_valid && ex_op != 111 && ex_rd != 0 && (in_rs1 == ex_rd || in_rs2 == ex_rd)`.
- **Load port:**
  - Writes `r[load_addr] <= load_data` on the edge.
  - A writeback to the same address on the same edge wins; the load is dropped.
  - Loads are not forwarded. An instruction accepted on the same edge as a load reads the pre-load value.

## Timing
- **Reset values:** all registers, `ex_*`, `alu_a`/`alu_b`/`alu_control`, `wb_valid`, `wb_rd`, `wb_data` and `flag_q` are 0.
- **`in_ready` during reset:** forced to 0 while `rst` is high.
- **`in_ready` outside reset:** 1, except 0 during a hazard when `ALU_ISSUE_FWD_EN` is undefined.
- **Latency:**
  - Accept at edge k: ALU inputs are valid after edge k.
  - Register write and `wb_valid` occur at edge k+1.
  - Result is visible on `dbg_data` after edge k+1.
- **Throughput:** 1 instruction/cycle; 1 per 2 cycles for back-to-back dependent ops without forwarding.
- **Reset mid-operation:** the EX instruction is squashed with no writeback. `in_ready` does not depend on `in_valid`.

## Configuration
- **`ALU_ISSUE_FWD_EN` defined:** hazards never stall. Any source equal to a hazarding `ex_rd` takes `alu_c` instead of the register-file value. Each source is resolved independently.
- **`ALU_ISSUE_FWD_EN` undefined:**
  - `in_ready = 0` whenever a hazard exists.
  - The EX slot drains on the next edge, the register file updates, and the instruction is accepted one cycle later reading the written value.
  - Sources always come from the register file.

## Test plan
- **Reset:** assert `rst` mid-stream. All outputs read 0 and `in_ready = 0`. Release: `in_ready = 1` and `dbg_data` reads 0 for every `dbg_addr`.
- **Basic add:** load r1=15, r2=5; issue add r3,r1,r2. Next cycle `alu_a=15`, `alu_b=5`, `alu_control=000`. Following cycle `wb_valid=1`, `wb_rd=3`, `wb_data=20`, r3=20.
- **Dependent chain:** add r3,r1,r2 then sub r4,r3,r2.
  - With FWD_EN: no stall, r4=15 at the second writeback.
  - Without FWD_EN: `in_ready=0` for exactly 1 cycle, r4=15.
- **r0 rules:** nand r0,r1,r2 → `wb_valid=1`, `wb_rd=0`, `flag_q=alu_f`, r0 still reads 0. A following add r5,r0,r1 gives r5=15 with no stall in either configuration.
- **NOP and contention:** NOP with rd=r1 followed by add r6,r1,r1 → no stall, r6=30, no `wb_valid` for the NOP. A load to r6 on the same edge as the writeback of r6 → r6=30.
- **Shifts/logic:** srl r2 → `alu_control=010`; sll → 110; nor → 011. Each writes back exactly the `alu_c` value the bench drives.
